// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the 8:1 TDM combiner and its round-robin arbiter.
package tdm_mux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping modulo 8.
module rr_arbiter_8
    import tdm_mux_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NCH-1:0]   gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + k[SEL_W-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux_8to1.sv
// Sequential 8:1 TDM combiner with a registered, channel-tagged output word.
// Optional even-parity output out_par is enabled with TDM_MUX_PARITY_EN.
//
// state | meaning
// IDLE  | output register empty
// HOLD  | out_valid high, waiting for out_ready
module tdm_mux_8to1
    import tdm_mux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef TDM_MUX_PARITY_EN
    ,
    output logic                  out_par
`endif
);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q;
    logic              load_ok;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any;
    logic [DATA_W-1:0] gnt_word;

    // A full output register may only reload on the same edge it drains.
    assign load_ok  = (state_q == IDLE) || (out_ready && out_valid);
    assign req      = load_ok ? in_valid : '0;
    assign in_ready = gnt;
    assign gnt_word = in_data[gnt_idx*DATA_W +: DATA_W];

    rr_arbiter_8 u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (any)                              state_d = HOLD;
        else if (state_q == HOLD && out_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (any) begin
            ptr_q     <= next_ptr(gnt_idx);
            out_data  <= gnt_word;
            out_sel   <= gnt_idx;
            out_valid <= 1'b1;
            out_last  <= (gnt_idx == 3'd7);
        end else if (state_q == HOLD && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef TDM_MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   out_par <= 1'b0;
        else if (any) out_par <= ^gnt_word;
    end
`endif

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Table-driven bench for tdm_mux_8to1 with an output scoreboard queue.
module tb_tdm_mux_8to1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_valid = '0;
    logic [7:0]  in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
`ifdef TDM_MUX_PARITY_EN
    logic        out_par;
`endif

    always #5 clk = ~clk;

    tdm_mux_8to1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef TDM_MUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    typedef struct {
        logic [7:0] v;
        logic       rdy;
        logic [7:0] d;
        logic [7:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] sel;
        logic       last;
    } out_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t q[$];
    logic mvalid = 1'b0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] d, input logic rdy);
        in_valid  = v;
        out_ready = rdy;
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = d + 8'(i);
    endtask

    task automatic check_out();
        chk("out_valid", {31'b0, out_valid}, {31'b0, mvalid});
        if (mvalid) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                chk("out_data", {24'b0, out_data}, {24'b0, q[0].data});
                chk("out_sel", {29'b0, out_sel}, {29'b0, q[0].sel});
                chk("out_last", {31'b0, out_last}, {31'b0, q[0].last});
`ifdef TDM_MUX_PARITY_EN
                chk("out_par", {31'b0, out_par}, {31'b0, ^q[0].data});
`endif
            end
        end else begin
            chk("out_last_idle", {31'b0, out_last}, 32'd0);
        end
    endtask

    task automatic step(input vec_t t);
        out_t e;
        @(negedge clk);
        drive(t.v, t.d, t.rdy);
        #1;
        chk("in_ready", {24'b0, in_ready}, {24'b0, t.exp_rdy});
        if (mvalid && t.rdy && q.size() > 0) void'(q.pop_front());
        @(posedge clk);
        if (t.exp_rdy != 8'h00) begin
            e.sel = '0;
            for (int i = 0; i < 8; i++) if (t.exp_rdy[i]) e.sel = 3'(i);
            e.data = t.d + {5'b0, e.sel};
            e.last = (e.sel == 3'd7);
            q.push_back(e);
            mvalid = 1'b1;
        end else if (t.rdy) begin
            mvalid = 1'b0;
        end
        #1;
        check_out();
    endtask

    function automatic vec_t mk(input logic [7:0] v, input logic rdy, input logic [7:0] d,
                                input logic [7:0] er);
        vec_t t;
        t.v = v; t.rdy = rdy; t.d = d; t.exp_rdy = er;
        return t;
    endfunction

    initial begin
        // reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_out_sel", {29'b0, out_sel}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_in_ready", {24'b0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // single channel 2, word 3C, then drain
        tbl.push_back(mk(8'h04, 1'b1, 8'h3A, 8'h04));
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00));
        // all valid streaming from ptr=3, one word per cycle
        tbl.push_back(mk(8'hFF, 1'b1, 8'h10, 8'h08));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h20, 8'h10));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h30, 8'h20));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h40, 8'h40));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h50, 8'h80));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h60, 8'h01));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h70, 8'h02));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h80, 8'h04));
        tbl.push_back(mk(8'hFF, 1'b1, 8'h90, 8'h08));
        tbl.push_back(mk(8'hFF, 1'b1, 8'hA0, 8'h10));
        // backpressure for 5 cycles, then reload on the draining edge
        for (int i = 0; i < 5; i++) tbl.push_back(mk(8'hFF, 1'b0, 8'hC0 + 8'(i), 8'h00));
        tbl.push_back(mk(8'hFF, 1'b1, 8'hD0, 8'h20));
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00));
        // wrap: ptr=6, channels 7 and 0
        tbl.push_back(mk(8'h81, 1'b1, 8'h01, 8'h80));
        tbl.push_back(mk(8'h81, 1'b1, 8'h02, 8'h01));
        tbl.push_back(mk(8'h81, 1'b1, 8'h03, 8'h80));
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00));
        // idle with out_ready low still accepts; stalled HOLD drops request
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00));
        tbl.push_back(mk(8'h01, 1'b0, 8'h55, 8'h01));
        tbl.push_back(mk(8'h02, 1'b0, 8'h66, 8'h00));
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00));
        // parity patterns 07 and FF on channel 0
        tbl.push_back(mk(8'h01, 1'b1, 8'h07, 8'h01));
        tbl.push_back(mk(8'h01, 1'b1, 8'hFF, 8'h01));
        tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00));

        foreach (tbl[i]) step(tbl[i]);

        // reset mid-HOLD with A5 held
        step(mk(8'h01, 1'b0, 8'hA5, 8'h01));
        step(mk(8'h00, 1'b0, 8'h00, 8'h00));
        chk("pre_rst_data", {24'b0, out_data}, 32'h0000_00A5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        mvalid = 1'b0;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, out_data}, 32'd0);
        chk("mid_rst_sel", {29'b0, out_sel}, 32'd0);
        chk("mid_rst_in_ready", {24'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(8'hFF, 1'b1, 8'hE0, 8'h01));
        step(mk(8'h00, 1'b1, 8'h00, 8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_mux_8to1.md
Name: tdm_mux_8to1

Overview:
- Sequential 8:1 multiplexer: the combining end of the 1:8 demux datapath.
- Collects words from 8 input channels with per-channel valid/ready, using round-robin arbitration.
- Presents one registered output word tagged with its 3-bit channel select. The select lines use the same ordering as the demux s1/s2/s3 inputs, so a downstream 1:8 demux can route each word back.

Parameters:
- DATA_W, 8, width of each channel word and of the output word.
- NCH, 8, number of input channels (fixed at 8; SEL_W = 3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*DATA_W  channel words; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NCH  per-channel request.
- in_ready  out  NCH  per-channel accept (combinational; at most one bit set).
- out_data  out  DATA_W  registered selected word.
- out_sel  out  3  channel index of out_data. Bit 2 corresponds to s1 (MSB), bit 0 to s3.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  high with out_valid when out_sel == 7 (end of scan frame).

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, out_data = 0, out_sel = 0, out_last = 0.
  - ptr = 0, state = IDLE, in_ready = 0.
- State machine (2 states):
  - IDLE: output register empty.
  - HOLD: out_valid = 1, waiting for out_ready.
- load_ok = (state == IDLE) || (out_ready && out_valid).
- Grant: when load_ok, pick the first channel i with in_valid[i] = 1, searching ptr, ptr+1, …, wrapping modulo 8.
  - in_ready[i] = 1 in that same cycle. All other in_ready bits = 0. No valid input means no grant.
- On a grant at edge N:
  - out_data <= word i, out_sel <= i, out_last <= (i == 7), out_valid <= 1.
  - ptr <= (i + 1) mod 8, so a grant on channel 7 wraps ptr to 0.
  - state <= HOLD.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and reload: out_ready && out_valid with a pending request reloads in the same edge. out_valid stays 1 and the state stays HOLD.
- Drain with no request: out_valid <= 0, state <= IDLE. ptr is unchanged.
- HOLD with out_ready = 0:
  - out_data, out_sel, out_last and out_valid are held stable.
  - in_ready = 0 on all channels.
- Input side: in_valid may drop without a grant (no input-side stickiness). Data is sampled only on the granted edge.
- Fairness: a continuously valid channel is granted within 8 output transfers.
- Reset asserted mid-transfer: the output word is discarded immediately and ptr returns to 0.

Optional Feature:
- Macro TDM_MUX_PARITY_EN.
- Defined:
  - Extra output port out_par (1 bit), registered alongside out_data, equal to the XOR of out_data (even parity). Reset value 0.
  - Holds with out_data in HOLD.
- Undefined: port absent; no other behaviour change.

Decomposition:
- Package tdm_mux_pkg:
  - NCH = 8, SEL_W = 3.
  - State enum {IDLE, HOLD}.
  - Function next_ptr (mod-8 increment).
- Sub-module rr_arbiter_8: combinational round-robin grant.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: gnt one-hot [7:0], gnt_idx[2:0], any.
- Top level holds the ptr register, the FSM and the output register.

Test Plan:
- Reset: rst_n = 0 mid-HOLD with out_data = 8'hA5 -> all outputs 0 immediately. After release, the first grant goes to channel 0.
- Single channel: in_valid = 8'b0000_0100, word 8'h3C, out_ready = 1 -> in_ready = 8'b0000_0100 that cycle. Next cycle out_valid = 1, out_data = 8'h3C, out_sel = 3'b010.
- All valid, out_ready = 1 for 10 cycles, channel i holding 8'h10+i -> out_sel sequence 0,1,…,7,0,1. out_last high on sel 7. One word per cycle.
- Backpressure: out_ready = 0 for 5 cycles during HOLD -> output stable, in_ready = 0. Release -> the next word loads on the same edge.
- Wrap fairness: ptr = 6, in_valid = 8'b1000_0001 -> grant channel 7 then channel 0, and ptr ends at 1.
- TDM_MUX_PARITY_EN defined, out_data = 8'b0000_0111 -> out_par = 1. out_data = 8'hFF -> out_par = 0.
